// File: rtl/sandbox_cmd_engine.sv
// Host-command sequencer: decodes a host word into engine fields, runs the
// engine request/result handshake with timeout, and returns status to the host.
module sandbox_cmd_engine #(
  parameter int unsigned FIELD_W     = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               masterClock,
  input  logic               reset,
  input  logic               slowClock,
  input  logic               dataReceived,
  input  logic [7:0]         control,
  input  logic [DATA_W-1:0]  inputData,
  output logic               clearDR,
  output logic               transmitData,
  input  logic               txAck,
  output logic [7:0]         status,
  output logic [DATA_W-1:0]  outputData,
  output logic               engValid,
  input  logic               engReady,
  output logic               engWrite,
  output logic               engIsMeta,
  output logic [FIELD_W-1:0] engIndex,
  output logic [FIELD_W-1:0] engValue,
  output logic [FIELD_W-1:0] engMeta,
  output logic [FIELD_W-1:0] engSel,
  input  logic               engResultValid,
  input  logic               engResultBool,
  input  logic [FIELD_W-1:0] engResultValue,
  output logic               rxIndicator
);

  if (DATA_W < 4 * FIELD_W) begin : g_bad_width
    $error("DATA_W must be at least 4*FIELD_W");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..65535");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RES, S_TX, S_CLEAR} state_t;
  typedef enum logic [1:0] {I_IDLE, I_ARM, I_WAIT_FALL, I_PULSE} ind_t;

  state_t            r_state;
  ind_t              r_ind;
  logic              r_mutate;
  logic [3:0]        r_seq;
  logic [15:0]       r_tmo_cnt;
  logic              r_slow_q;
  logic [15:0]       w_tmo_next;
  logic              w_tmo_hit;
  logic              w_accept;
  logic              w_slow_fall;
  logic [DATA_W-1:0] w_result_word;

  always_comb begin
    w_tmo_next    = r_tmo_cnt + 16'd1;
    w_tmo_hit     = (w_tmo_next == 16'(TIMEOUT_CYC));
    w_accept      = (r_state == S_IDLE) && dataReceived;
    w_slow_fall   = r_slow_q && !slowClock;
    w_result_word = '0;
    w_result_word[DATA_W-1 -: FIELD_W] = engResultValue;
  end

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mutate     <= 1'b0;
      r_seq        <= '0;
      r_tmo_cnt    <= '0;
      clearDR      <= 1'b0;
      transmitData <= 1'b0;
      status       <= '0;
      outputData   <= '0;
      engValid     <= 1'b0;
      engWrite     <= 1'b0;
      engIsMeta    <= 1'b0;
      engIndex     <= '0;
      engValue     <= '0;
      engMeta      <= '0;
      engSel       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dataReceived) begin
            r_mutate  <= control[0];
            engWrite  <= control[2] & control[0];
            engIsMeta <= control[1];
            engIndex  <= inputData[0*FIELD_W +: FIELD_W];
            engValue  <= inputData[1*FIELD_W +: FIELD_W];
            engMeta   <= inputData[2*FIELD_W +: FIELD_W];
            engSel    <= inputData[3*FIELD_W +: FIELD_W];
            r_tmo_cnt <= '0;
            engValid  <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmo_cnt <= w_tmo_next;
          // A mutate transfer is a completion and beats the timeout; a query
          // transfer is not, so a timeout on that edge still aborts.
          if (engReady && r_mutate) begin
            engValid   <= 1'b0;
            status     <= {r_seq, 4'b0101};
            outputData <= '0;
            r_state    <= S_TX;
          end else if (w_tmo_hit) begin
            engValid   <= 1'b0;
            status     <= {r_seq, 1'b0, r_mutate, 2'b10};
            outputData <= '0;
            r_state    <= S_TX;
          end else if (engReady) begin
            engValid   <= 1'b0;
            r_state    <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          r_tmo_cnt <= w_tmo_next;
          if (engResultValid) begin
            status     <= {r_seq, 1'b0, r_mutate, 1'b0, engResultBool};
            outputData <= w_result_word;
            r_state    <= S_TX;
          end else if (w_tmo_hit) begin
            status     <= {r_seq, 1'b0, r_mutate, 2'b10};
            outputData <= '0;
            r_state    <= S_TX;
          end
        end
        S_TX: begin
          if (!transmitData) begin
            transmitData <= 1'b1;
          end else if (txAck) begin
            transmitData <= 1'b0;
            r_seq        <= r_seq + 4'd1;
            clearDR      <= 1'b1;
            r_state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (!dataReceived) begin
            clearDR <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Indicator: arm on acceptance, then pulse from one slowClock fall to the next.
  always_ff @(posedge masterClock) begin
    if (!reset) begin
      r_ind       <= I_IDLE;
      r_slow_q    <= 1'b0;
      rxIndicator <= 1'b0;
    end else begin
      r_slow_q <= slowClock;
      case (r_ind)
        I_IDLE:      if (w_accept) r_ind <= I_ARM;
        I_ARM:       if (slowClock) r_ind <= I_WAIT_FALL;
        I_WAIT_FALL: if (w_slow_fall) begin
                       rxIndicator <= 1'b1;
                       r_ind       <= I_PULSE;
                     end
        I_PULSE:     if (w_slow_fall) begin
                       rxIndicator <= 1'b0;
                       r_ind       <= I_IDLE;
                     end
        default:     r_ind <= I_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sandbox_cmd_engine.sv
// Randomized bench for sandbox_cmd_engine; expected outcomes are computed from
// edge-count arithmetic (transfer edge, completion edge, timeout edge).
module tb_sandbox_cmd_engine;
  localparam int unsigned FW  = 8;
  localparam int unsigned DW  = 32;
  localparam int          TMO = 16;

  logic          masterClock, reset, slowClock, dataReceived, txAck;
  logic [7:0]    control;
  logic [DW-1:0] inputData, outputData;
  logic          clearDR, transmitData, engValid, engReady, engWrite, engIsMeta;
  logic [7:0]    status;
  logic [FW-1:0] engIndex, engValue, engMeta, engSel, engResultValue;
  logic          engResultValid, engResultBool, rxIndicator;

  sandbox_cmd_engine #(.FIELD_W(FW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) u_dut (
    .masterClock(masterClock), .reset(reset), .slowClock(slowClock),
    .dataReceived(dataReceived), .control(control), .inputData(inputData),
    .clearDR(clearDR), .transmitData(transmitData), .txAck(txAck),
    .status(status), .outputData(outputData), .engValid(engValid),
    .engReady(engReady), .engWrite(engWrite), .engIsMeta(engIsMeta),
    .engIndex(engIndex), .engValue(engValue), .engMeta(engMeta), .engSel(engSel),
    .engResultValid(engResultValid), .engResultBool(engResultBool),
    .engResultValue(engResultValue), .rxIndicator(rxIndicator)
  );

  initial masterClock = 1'b0;
  always #5 masterClock = ~masterClock;

  // Slow indicator clock: 16 master cycles per period, changed on negedges.
  initial begin
    slowClock = 1'b0;
    forever begin
      repeat (8) @(negedge masterClock);
      slowClock = ~slowClock;
    end
  end

  int         n_checks;
  int         n_errors;
  logic [3:0] m_seq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine stimulus for upcoming edge k of a command (edge 0 = acceptance).
  task automatic drive_eng(input int k, input int d, input int res_edge,
                           input bit rb, input logic [7:0] rv);
    engReady       = (k >= 1 + d);
    engResultValid = (k == res_edge);
    engResultBool  = (k == res_edge) ? rb : 1'($urandom);
    engResultValue = (k == res_edge) ? rv : 8'($urandom);
  endtask

  // ackd < 0: txAck already high before transmitData rises.
  task automatic run_cmd(input logic [7:0] ctrl, input logic [31:0] data,
                         input int d, input int r, input int ackd, input int drh,
                         input bit rb, input logic [7:0] rv, input int exp_lat);
    bit          mut, tmo, stable;
    int          f_edge, x_edge, res_edge, k, rise, vcount, hold, cl;
    logic [7:0]  exp_status;
    logic [31:0] exp_out;
    mut = ctrl[0];
    if (mut) begin
      tmo      = (1 + d > TMO);
      f_edge   = tmo ? TMO : 1 + d;
      res_edge = -1;
    end else begin
      tmo      = (2 + d + r > TMO);
      f_edge   = tmo ? TMO : 2 + d + r;
      res_edge = 2 + d + r;
    end
    x_edge     = (1 + d < TMO) ? 1 + d : TMO;
    exp_status = {m_seq, 1'b0, mut, tmo, tmo ? 1'b0 : (mut ? 1'b1 : rb)};
    exp_out    = (tmo || mut) ? 32'h0 : {rv, 24'h0};

    control      = ctrl;
    inputData    = data;
    dataReceived = 1'b1;
    txAck        = (ackd < 0);
    drive_eng(0, d, res_edge, rb, rv);
    @(negedge masterClock);
    check("valid_rise", {31'h0, engValid}, 32'h1);
    check("fields", {engSel, engMeta, engValue, engIndex}, data);

    k = 1; rise = -1; vcount = 0;
    while (rise < 0 && k < 200) begin
      if (engValid) vcount++;
      drive_eng(k, d, res_edge, rb, rv);
      @(negedge masterClock);
      if (transmitData) rise = k; else k++;
    end
    check("tx_rise_edge", rise, f_edge + 1);
    if (rise < 0) begin
      $display("FAIL tx_wait: transmitData never rose");
      return;
    end
    if (exp_lat > 0) check("latency", rise + 1, exp_lat);
    check("valid_len", vcount, x_edge);
    check("status", {24'h0, status}, {24'h0, exp_status});
    check("outputData", outputData, exp_out);
    check("fields_hold", {engSel, engMeta, engValue, engIndex}, data);
    check("eng_flags", {30'h0, engWrite, engIsMeta}, {30'h0, ctrl[2] & ctrl[0], ctrl[1]});

    hold = 1; stable = 1'b1;
    for (int j = 0; j < 100; j++) begin
      txAck = (ackd < 0) || (j >= ackd);
      k++;
      drive_eng(k, d, res_edge, rb, rv);
      @(negedge masterClock);
      if (!transmitData) break;
      hold++;
      if (status !== exp_status || outputData !== exp_out || clearDR !== 1'b0) stable = 1'b0;
    end
    check("tx_hold", hold, (ackd < 0) ? 1 : ackd + 1);
    check("tx_stable", {31'h0, stable}, 32'h1);
    check("clear_on_ack", {31'h0, clearDR}, 32'h1);

    txAck = 1'b0;
    cl = 0;
    while (clearDR && cl < 50) begin
      cl++;
      dataReceived = (cl <= drh);
      k++;
      drive_eng(k, d, res_edge, rb, rv);
      @(negedge masterClock);
    end
    check("clear_len", cl, drh + 1);
    dataReceived   = 1'b0;
    engReady       = 1'b0;
    engResultValid = 1'b0;
    m_seq++;
    @(negedge masterClock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_status"}, {24'h0, status}, 32'h0);
    check({tag, "_out"}, outputData, 32'h0);
    check({tag, "_fields"}, {engSel, engMeta, engValue, engIndex}, 32'h0);
    check({tag, "_flags"},
          {26'h0, clearDR, transmitData, engValid, engWrite, engIsMeta, rxIndicator}, 32'h0);
  endtask

  initial begin
    int ind_rise, ind_width;
    n_checks = 0; n_errors = 0; m_seq = '0;
    reset = 1'b0; dataReceived = 1'b0; txAck = 1'b0; control = '0; inputData = '0;
    engReady = 1'b0; engResultValid = 1'b0; engResultBool = 1'b0; engResultValue = '0;
    repeat (3) @(negedge masterClock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge masterClock);

    run_cmd(8'h05, 32'h04030201, 0, 0, 5, 3, 1'b0, 8'h00, 3);          // mutate write
    run_cmd(8'h00, 32'h1234_5678, 0, 1, 2, 1, 1'b1, 8'hA5, 0);         // query hit, seq 1
    run_cmd(8'h00, 32'hCAFE_F00D, 0, 0, -1, 0, 1'b0, 8'h3C, 4);        // min query latency
    run_cmd(8'h02, 32'hDEAD_BEEF, 10, 0, 1, 0, 1'b1, 8'h77, 0);        // back-pressure
    run_cmd(8'h00, 32'h0BAD_0BAD, 0, 40, 25, 2, 1'b1, 8'hFF, 0);       // timeout, late result
    run_cmd(8'h05, 32'h1111_2222, 20, 0, 0, 0, 1'b0, 8'h00, 0);        // mutate timeout
    run_cmd(8'h00, 32'h3333_4444, 0, 14, 0, 0, 1'b1, 8'h5A, 0);        // completion on timeout edge
    run_cmd(8'h07, 32'h5555_6666, 15, 0, 0, 0, 1'b0, 8'h00, 0);        // mutate on timeout edge

    // Reset while waiting for a result abandons the command.
    control = 8'h00; inputData = 32'h9999_8888; dataReceived = 1'b1; engReady = 1'b1;
    @(negedge masterClock);
    @(negedge masterClock);
    reset = 1'b0;
    @(negedge masterClock);
    check_all_zero("midreset");
    reset = 1'b1; dataReceived = 1'b0; engReady = 1'b0;
    m_seq = '0;
    @(negedge masterClock);

    for (int i = 0; i < 20; i++) begin
      int ad;
      ad = int'($urandom_range(0, 6)) - 1;
      run_cmd(8'($urandom), $urandom, int'($urandom_range(0, 16)), int'($urandom_range(0, 14)),
              ad, int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 0);
    end

    // Indicator pulse spans one full slowClock period (16 master cycles).
    repeat (64) @(negedge masterClock);
    ind_rise = -1; ind_width = 0;
    fork
      run_cmd(8'h01, 32'h0102_0304, 0, 0, 0, 0, 1'b0, 8'h00, 0);
      begin
        for (int j = 0; j < 100 && ind_rise < 0; j++) begin
          @(negedge masterClock);
          if (rxIndicator) ind_rise = j;
        end
        while (rxIndicator && ind_width < 100) begin
          ind_width++;
          @(negedge masterClock);
        end
      end
    join
    check("ind_seen", {31'h0, ind_rise >= 0}, 32'h1);
    check("ind_width", ind_width, 16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
